prog_mem: RTL and testbench

PROG_MEM -- requirements
Module: prog_mem

---
 rtl/prog_mem_pkg.sv | 17 +
 rtl/prog_mem_ld_ctr.sv | 39 +++
 rtl/prog_mem.sv | 123 ++++++++++++
 tb/tb_prog_mem.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_pkg.sv
// Shared sizing and FSM encoding for the program memory and its loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package prog_mem_pkg;

  localparam int PM_AW    = 7;
  localparam int PM_DW    = 16;
  localparam int PM_DEPTH = 128;

  // HOLD: processor parked, no burst; LOAD: burst in progress; RUN: processor free.
  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/prog_mem_ld_ctr.sv
// Burst write pointer and remaining-word counter for the loader.
// Latency: load/step take effect on the next rising clk edge; last is combinational.
// Backpressure: none; steps only when the parent signals a completed transfer.
module ld_ctr #(
  parameter int AW    = 7,
  parameter int DEPTH = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  input  logic          step,
  output logic [AW-1:0] ptr,
  output logic [AW:0]   remaining,
  output logic          last
);

  // The pointer wraps explicitly so a non-power-of-two DEPTH still stays in range.
  logic [AW-1:0] ptr_inc;
  assign ptr_inc = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  assign last = (remaining == (AW+1)'(1));

  // Latch a new burst on load, otherwise advance one word per transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      remaining <= '0;
    end else if (load) begin
      ptr       <= base;
      remaining <= count;
    end else if (step) begin
      ptr       <= ptr_inc;
      remaining <= remaining - 1'b1;
    end
  end

endmodule

// File: rtl/prog_mem.sv
// Program memory with a burst loader that holds the processor in reset while loading.
// Latency: reads are combinational; writes and control changes land on the next rising clk edge.
// Backpressure: ld_ready is high only in LOAD; ld_valid gaps simply stall the burst.
module prog_mem
  import prog_mem_pkg::*;
#(
  parameter int AW    = PM_AW,
  parameter int DW    = PM_DW,
  parameter int DEPTH = PM_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_data,
  output logic          cpu_hold,
  input  logic          ld_start,
  input  logic [AW-1:0] ld_base,
  input  logic [AW:0]   ld_count,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          ld_go,
  output logic          ld_done,
  output logic          ld_err
);

  state_t        state;
  logic          start_ok;
  logic          start_bad;
  logic          xfer;
  logic          ctr_load;
  logic [AW-1:0] ptr;
  logic [AW:0]   remaining;
  logic          last;

  logic [DW-1:0] mem [DEPTH];

  // A burst length must be 1..DEPTH; anything else is rejected with ld_err.
  assign start_ok  = ld_start && (ld_count != '0) && (ld_count <= (AW+1)'(DEPTH));
  assign start_bad = ld_start && !start_ok;

  // Transfers only count while loading; ld_ready mirrors that state.
  assign xfer     = (state == ST_LOAD) && ld_valid;
  assign ctr_load = start_ok && (state != ST_LOAD);

  ld_ctr #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ld_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (ctr_load),
    .base      (ld_base),
    .count     (ld_count),
    .step      (xfer),
    .ptr       (ptr),
    .remaining (remaining),
    .last      (last)
  );

  // Control FSM; cpu_hold and ld_ready are registered alongside the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_HOLD;
      cpu_hold <= 1'b1;
      ld_ready <= 1'b0;
      ld_done  <= 1'b0;
      ld_err   <= 1'b0;
    end else begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      case (state)
        ST_HOLD: begin
          if (start_ok) begin
            state    <= ST_LOAD;
            cpu_hold <= 1'b1;
            ld_ready <= 1'b1;
          end else if (start_bad) begin
            ld_err <= 1'b1;
          end else if (ld_go) begin
            state    <= ST_RUN;
            cpu_hold <= 1'b0;
            ld_ready <= 1'b0;
          end
        end
        ST_LOAD: begin
          // ld_start and ld_go are deliberately ignored mid-burst.
          if (xfer && last) begin
            state    <= ST_RUN;
            cpu_hold <= 1'b0;
            ld_ready <= 1'b0;
            ld_done  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start_ok) begin
            state    <= ST_LOAD;
            cpu_hold <= 1'b1;
            ld_ready <= 1'b1;
          end else if (start_bad) begin
            ld_err <= 1'b1;
          end
        end
        default: begin
          state    <= ST_HOLD;
          cpu_hold <= 1'b1;
          ld_ready <= 1'b0;
        end
      endcase
    end
  end

  // Storage write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (xfer) begin
      mem[ptr] <= ld_data;
    end
  end

  // Asynchronous read port: a same-cycle write is seen only from the next cycle.
  assign cpu_data = mem[cpu_addr];

endmodule

// File: tb/tb_prog_mem.sv
// Randomized bench for prog_mem with a queue-based scoreboard and an abstract model.
// Latency: n/a.
// Backpressure: n/a.
module tb_prog_mem;

  localparam int AW    = 7;
  localparam int DW    = 16;
  localparam int DEPTH = 128;

  localparam int P_HOLD = 0;
  localparam int P_LOAD = 1;
  localparam int P_RUN  = 2;

  localparam logic [1:0] EV_DONE = 2'b10;
  localparam logic [1:0] EV_ERR  = 2'b01;

  typedef struct {
    logic [1:0] kind;
    int         cyc;
  } evt_t;

  logic          clk;
  logic          reset;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_data;
  logic          cpu_hold;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW:0]   ld_count;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          ld_go;
  logic          ld_done;
  logic          ld_err;

  prog_mem #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu_addr (cpu_addr),
    .cpu_data (cpu_data),
    .cpu_hold (cpu_hold),
    .ld_start (ld_start),
    .ld_base  (ld_base),
    .ld_count (ld_count),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_go    (ld_go),
    .ld_done  (ld_done),
    .ld_err   (ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image, abstract phase, burst pointer and words left.
  logic [DW-1:0] ref_mem [DEPTH];
  bit            known   [DEPTH];
  int            phase = P_HOLD;
  int            mptr  = 0;
  int            mrem  = 0;

  logic [DW-1:0] rd_q [$];
  evt_t          evt_q [$];
  bit            rd_vld = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares control outputs, pending reads and pulse events each cycle.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    evt_t          e;
    checks++;
    if (cpu_hold !== (phase != P_RUN) || ld_ready !== (phase == P_LOAD)) begin
      errors++;
      $display("FAIL ctrl @%0d: cpu_hold=%b ld_ready=%b, expected cpu_hold=%b ld_ready=%b",
               cyc, cpu_hold, ld_ready, (phase != P_RUN), (phase == P_LOAD));
    end
    if (rd_vld) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL read_q @%0d: read presented with no expectation queued", cyc);
      end else begin
        exp_d = rd_q.pop_front();
        if (cpu_data !== exp_d) begin
          errors++;
          $display("FAIL read @%0d addr=%0d: got %h expected %h", cyc, cpu_addr, cpu_data, exp_d);
        end
      end
    end
    if (evt_q.size() != 0 && evt_q[0].cyc == cyc) begin
      e = evt_q.pop_front();
      checks++;
      if ({ld_done, ld_err} !== e.kind) begin
        errors++;
        $display("FAIL pulse @%0d: {ld_done,ld_err}=%b expected %b", cyc, {ld_done, ld_err}, e.kind);
      end
    end else if (ld_done || ld_err) begin
      checks++;
      errors++;
      $display("FAIL stray_pulse @%0d: {ld_done,ld_err}=%b expected 00", cyc, {ld_done, ld_err});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int base, input int cnt, input bit go);
    int nxt = phase;
    ld_start = 1'b1;
    ld_base  = AW'(base);
    ld_count = (AW+1)'(cnt);
    ld_go    = go;
    if (phase != P_LOAD) begin
      if (cnt >= 1 && cnt <= DEPTH) begin
        nxt  = P_LOAD;
        mptr = base;
        mrem = cnt;
      end else begin
        evt_q.push_back('{kind: EV_ERR, cyc: cyc + 1});
      end
    end
    tick();
    ld_start = 1'b0;
    ld_go    = 1'b0;
    phase    = nxt;
  endtask

  task automatic do_go();
    ld_go = 1'b1;
    tick();
    ld_go = 1'b0;
    if (phase == P_HOLD) phase = P_RUN;
  endtask

  // One accepted loader word; also reads the target address to see the old word.
  task automatic xfer(input logic [DW-1:0] d);
    cpu_addr = AW'(mptr);
    if (known[mptr]) begin
      rd_q.push_back(ref_mem[mptr]);
      rd_vld = 1'b1;
    end
    ld_valid = 1'b1;
    ld_data  = d;
    if (mrem == 1) evt_q.push_back('{kind: EV_DONE, cyc: cyc + 1});
    tick();
    ld_valid      = 1'b0;
    rd_vld        = 1'b0;
    ref_mem[mptr] = d;
    known[mptr]   = 1'b1;
    mptr          = (mptr + 1) % DEPTH;
    mrem--;
    if (mrem == 0) phase = P_RUN;
  endtask

  // Gap cycles inside a burst, optionally poking ld_start/ld_go (must be ignored).
  task automatic idle(input int n, input bit poke);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b0;
      ld_data  = DW'($urandom);
      cpu_addr = AW'(mptr);
      if (known[mptr]) begin
        rd_q.push_back(ref_mem[mptr]);
        rd_vld = 1'b1;
      end
      if (poke) begin
        ld_start = 1'b1;
        ld_base  = AW'($urandom);
        ld_count = (AW+1)'($urandom_range(0, 200));
        ld_go    = 1'b1;
      end
      tick();
      rd_vld   = 1'b0;
      ld_start = 1'b0;
      ld_go    = 1'b0;
    end
  endtask

  task automatic rd(input int a);
    cpu_addr = AW'(a);
    if (known[a % DEPTH]) begin
      rd_q.push_back(ref_mem[a % DEPTH]);
      rd_vld = 1'b1;
    end
    @(negedge clk);
    #1;
    rd_vld = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    phase = P_HOLD;
    mrem  = 0;
    @(negedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset    = 1'b0;
    cpu_addr = '0;
    ld_start = 1'b0;
    ld_base  = '0;
    ld_count = '0;
    ld_valid = 1'b0;
    ld_data  = '0;
    ld_go    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      known[i]   = 1'b0;
      ref_mem[i] = '0;
    end
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Basic three-word burst from HOLD, then read it back in RUN.
    do_start(0, 3, 1'b0);
    xfer(16'h1111);
    xfer(16'h2222);
    xfer(16'h3333);
    for (int a = 0; a < 3; a++) rd(a);

    // Fill the whole array from RUN so every later read has a known value.
    do_start(0, DEPTH, 1'b0);
    for (int i = 0; i < DEPTH; i++) xfer(DW'($urandom));
    for (int i = 0; i < 8; i++) rd($urandom_range(0, DEPTH - 1));

    // Wrap-around burst.
    do_start(126, 4, 1'b0);
    for (int i = 0; i < 4; i++) xfer(DW'($urandom));
    rd(125); rd(126); rd(127); rd(0); rd(1); rd(2);

    // Rejected lengths in HOLD, memory kept across reset, then release.
    pulse_reset();
    do_start(0, 0, 1'b0);
    do_start(0, 129, 1'b0);
    idle(2, 1'b0);
    rd(0); rd(127);
    do_go();
    do_start(5, 0, 1'b0);

    // Burst stalled by a 5-cycle ld_valid gap with ignored start/go pokes.
    do_start(10, 6, 1'b0);
    for (int i = 0; i < 3; i++) xfer(DW'($urandom));
    idle(5, 1'b1);
    for (int i = 0; i < 3; i++) xfer(DW'($urandom));
    for (int a = 9; a < 17; a++) rd(a);

    // Reset after two of four words.
    do_start(40, 4, 1'b0);
    xfer(DW'($urandom));
    xfer(DW'($urandom));
    pulse_reset();
    for (int a = 40; a < 44; a++) rd(a);
    do_go();
    rd(41);

    // Start and go together in HOLD: start wins.
    pulse_reset();
    do_start(60, 2, 1'b1);
    xfer(DW'($urandom));
    xfer(DW'($urandom));
    rd(60); rd(61);

    // Reload from RUN.
    do_start(70, 2, 1'b0);
    xfer(DW'($urandom));
    xfer(DW'($urandom));
    rd(70); rd(71);

    // Randomized mix of bursts, bad lengths, gaps, resets and releases.
    for (int it = 0; it < 40; it++) begin
      int cnt;
      if ($urandom_range(0, 9) == 0) pulse_reset();
      if (phase == P_HOLD && $urandom_range(0, 1) == 1) do_go();
      case ($urandom_range(0, 9))
        0:       cnt = 0;
        1:       cnt = $urandom_range(129, 255);
        default: cnt = $urandom_range(1, 12);
      endcase
      do_start($urandom_range(0, DEPTH - 1), cnt, 1'($urandom_range(0, 1)));
      while (phase == P_LOAD && mrem > 0) begin
        if ($urandom_range(0, 59) == 0) begin
          pulse_reset();
          break;
        end
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
        xfer(DW'($urandom));
      end
      for (int k = 0; k < 3; k++) rd($urandom_range(0, DEPTH - 1));
    end

    tick();
    tick();
    checks++;
    if (evt_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: %0d expected pulses never seen, expected 0", evt_q.size());
    end
    checks++;
    if (rd_q.size() != 0) begin
      errors++;
      $display("FAIL pending_reads: %0d queued reads unchecked, expected 0", rd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
